// File: rtl/movavg_mux_scheduler.sv
// Multi-channel moving-average engine: a round-robin arbiter picks one requester
// per cycle and a shared add/subtract/shift datapath updates that channel's window.
module movavg_mux_scheduler #(
  parameter  int WIDTH     = 16,
  parameter  int WINDOW    = 4,
  parameter  int NCHAN     = 3,
  localparam int SW        = $clog2(WINDOW),
  localparam int CW        = (NCHAN > 1) ? $clog2(NCHAN) : 1,
  localparam int SUM_WIDTH = WIDTH + SW
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     clear,
  input  logic [NCHAN-1:0]         ch_valid,
  input  logic [NCHAN*WIDTH-1:0]   ch_data,
  output logic [NCHAN-1:0]         ch_ready,
  output logic                     ovalid,
  input  logic                     oready,
  output logic [CW-1:0]            ochan,
  output logic signed [WIDTH-1:0]  odata,
  output logic                     ofull
);

  // Handshake: an input sample moves on an edge with ch_valid[i] & ch_ready[i];
  // a result moves on an edge with ovalid & oready. ch_ready is combinational
  // from ch_valid, so producers must never wait for ch_ready before raising valid.

  logic [CW-1:0]               last;
  logic signed [WIDTH-1:0]     hist [NCHAN][WINDOW];
  logic signed [SUM_WIDTH-1:0] sum  [NCHAN];
  logic [SW:0]                 fill [NCHAN];
  logic [SW-1:0]               wptr [NCHAN];
  logic signed [WIDTH-1:0]     sample [NCHAN];

  logic                        free;
  logic                        xfer;
  logic [CW-1:0]               gidx;
  logic [CW:0]                 cand;

  logic signed [WIDTH-1:0]     x;
  logic signed [WIDTH-1:0]     old;
  logic signed [SUM_WIDTH-1:0] ext_x;
  logic signed [SUM_WIDTH-1:0] ext_old;
  logic signed [SUM_WIDTH-1:0] sum_new;
  logic [SW:0]                 fill_new;
  logic                        full_now;

  always_comb begin
    for (int i = 0; i < NCHAN; i++) begin
      sample[i] = ch_data[i*WIDTH +: WIDTH];
    end
  end

  assign free = !ovalid || oready;

  // Scan starts one past the last winner so every requester is served in turn.
  always_comb begin
    xfer = 1'b0;
    gidx = '0;
    cand = '0;
    if (reset_n && !clear && free) begin
      for (int k = 1; k <= NCHAN; k++) begin
        cand = {1'b0, last} + (CW+1)'(k);
        if (cand >= (CW+1)'(NCHAN)) begin
          cand = cand - (CW+1)'(NCHAN);
        end
        if (!xfer && ch_valid[cand[CW-1:0]]) begin
          xfer = 1'b1;
          gidx = cand[CW-1:0];
        end
      end
    end
  end

  always_comb begin
    ch_ready = '0;
    if (xfer) begin
      ch_ready[gidx] = 1'b1;
    end
  end

  // Shared datapath: the oldest sample is subtracted only once the window is full.
  always_comb begin
    x        = sample[gidx];
    old      = hist[gidx][wptr[gidx]];
    ext_x    = {{SW{x[WIDTH-1]}}, x};
    ext_old  = {{SW{old[WIDTH-1]}}, old};
    full_now = (fill[gidx] == (SW+1)'(WINDOW));
    if (full_now) begin
      sum_new  = sum[gidx] + ext_x - ext_old;
      fill_new = fill[gidx];
    end else begin
      sum_new  = sum[gidx] + ext_x;
      fill_new = fill[gidx] + (SW+1)'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      last   <= CW'(NCHAN-1);
      ovalid <= 1'b0;
      ochan  <= '0;
      odata  <= '0;
      ofull  <= 1'b0;
      for (int i = 0; i < NCHAN; i++) begin
        sum[i]  <= '0;
        fill[i] <= '0;
        wptr[i] <= '0;
        for (int j = 0; j < WINDOW; j++) begin
          hist[i][j] <= '0;
        end
      end
    end else begin
      if (clear) begin
        // History is left alone: it is unreachable until the window refills.
        for (int i = 0; i < NCHAN; i++) begin
          sum[i]  <= '0;
          fill[i] <= '0;
          wptr[i] <= '0;
        end
      end else if (xfer) begin
        sum[gidx]             <= sum_new;
        fill[gidx]            <= fill_new;
        wptr[gidx]            <= wptr[gidx] + SW'(1);
        hist[gidx][wptr[gidx]] <= x;
        last                  <= gidx;
      end

      if (xfer) begin
        ovalid <= 1'b1;
        ochan  <= gidx;
        odata  <= sum_new[SUM_WIDTH-1:SW];
        ofull  <= (fill_new == (SW+1)'(WINDOW));
      end else if (ovalid && oready) begin
        ovalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_movavg_mux_scheduler.sv
// Directed plus randomized bench; a queue-based window model predicts every result.
module tb_movavg_mux_scheduler;

  localparam int WIDTH  = 16;
  localparam int WINDOW = 4;
  localparam int NCHAN  = 3;
  localparam int CW     = 2;
  localparam int EW     = 1 + CW + WIDTH;

  logic                    clock;
  logic                    reset_n;
  logic                    clear;
  logic [NCHAN-1:0]        ch_valid;
  logic [NCHAN*WIDTH-1:0]  ch_data;
  logic [NCHAN-1:0]        ch_ready;
  logic                    ovalid;
  logic                    oready;
  logic [CW-1:0]           ochan;
  logic signed [WIDTH-1:0] odata;
  logic                    ofull;

  int checks = 0;
  int errors = 0;

  logic [EW-1:0] exp_q[$];
  int            hist_q[NCHAN][$];

  logic mon_take;
  int   mon_g;
  int   mon_x;
  int   exp_g;

  movavg_mux_scheduler #(.WIDTH(WIDTH), .WINDOW(WINDOW), .NCHAN(NCHAN)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .clear    (clear),
    .ch_valid (ch_valid),
    .ch_data  (ch_data),
    .ch_ready (ch_ready),
    .ovalid   (ovalid),
    .oready   (oready),
    .ochan    (ochan),
    .odata    (odata),
    .ofull    (ofull)
  );

  // Clock and watchdog
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: the window is the last WINDOW samples; the average is floor(sum/WINDOW).
  task automatic model_accept(input int ch, input int xv);
    int s;
    int avg;
    logic [WIDTH-1:0] avg_w;
    logic full_b;
    hist_q[ch].push_back(xv);
    if (hist_q[ch].size() > WINDOW) void'(hist_q[ch].pop_front());
    s = 0;
    for (int j = 0; j < hist_q[ch].size(); j++) s += hist_q[ch][j];
    if (s >= 0) avg = s / WINDOW;
    else        avg = -((-s + WINDOW - 1) / WINDOW);
    avg_w  = WIDTH'(avg);
    full_b = (hist_q[ch].size() == WINDOW);
    exp_q.push_back({full_b, CW'(ch), avg_w});
  endtask

  task automatic model_flush();
    for (int i = 0; i < NCHAN; i++) hist_q[i].delete();
  endtask

  // Scoreboard: handshakes sampled at the edge, outputs checked 1 time unit later.
  always begin
    @(posedge clock);
    if (reset_n) begin
      mon_take = ovalid && oready;
      mon_g    = -1;
      check("grant_onehot0", 64'($onehot0(ch_ready)), 64'd1);
      for (int i = 0; i < NCHAN; i++) begin
        if (ch_valid[i] && ch_ready[i]) begin
          mon_g = i;
          mon_x = int'($signed(ch_data[i*WIDTH +: WIDTH]));
        end
      end
      if (clear) begin
        check("no_grant_on_clear", 64'(ch_ready), 64'd0);
        model_flush();
      end
      if (mon_take) begin
        check("take_has_expectation", 64'(exp_q.size()), 64'd1);
        if (exp_q.size() > 0) void'(exp_q.pop_front());
      end
      if (mon_g >= 0) model_accept(mon_g, mon_x);
    end
    #1;
    if (reset_n) begin
      if (ovalid) begin
        check("pending_expectation", 64'(exp_q.size()), 64'd1);
        if (exp_q.size() > 0) check("result", 64'({ofull, ochan, odata}), 64'(exp_q[0]));
      end else begin
        check("idle_queue_empty", 64'(exp_q.size()), 64'd0);
      end
    end
  end

  // Driver: present one sample on one channel, wait for its grant, check the result.
  task automatic send(input int ch, input int xv, input int exp_avg, input bit exp_full);
    int n;
    @(negedge clock);
    ch_valid     = '0;
    ch_valid[ch] = 1'b1;
    ch_data[ch*WIDTH +: WIDTH] = WIDTH'(xv);
    oready = 1'b1;
    #1;
    n = 0;
    while (!ch_ready[ch] && n < 20) begin
      @(negedge clock);
      #1;
      n++;
    end
    check("send_grant", 64'(ch_ready[ch]), 64'd1);
    @(posedge clock);
    #2;
    ch_valid = '0;
    check("send_ovalid", 64'(ovalid), 64'd1);
    check("send_ochan",  64'(ochan),  64'(ch));
    check("send_odata",  64'(odata),  64'(WIDTH'(exp_avg)));
    check("send_ofull",  64'(ofull),  64'(exp_full));
  endtask

  initial begin
    reset_n  = 1'b0;
    clear    = 1'b0;
    oready   = 1'b1;
    ch_valid = '1;
    ch_data  = {16'($urandom), 16'($urandom), 16'($urandom)};

    // Reset held with every channel requesting
    repeat (3) begin
      @(negedge clock);
      check("rst_ovalid", 64'(ovalid),   64'd0);
      check("rst_odata",  64'(odata),    64'd0);
      check("rst_ochan",  64'(ochan),    64'd0);
      check("rst_ofull",  64'(ofull),    64'd0);
      check("rst_ready",  64'(ch_ready), 64'd0);
    end
    reset_n = 1'b1;
    #1;
    check("first_grant", 64'(ch_ready), 64'b001);
    ch_valid = '0;

    // Single channel warm-up and steady state
    send(0, 4,  1,  1'b0);
    send(0, 8,  3,  1'b0);
    send(0, 12, 6,  1'b0);
    send(0, 16, 10, 1'b1);
    send(0, 20, 14, 1'b1);

    // Negative values round toward minus infinity
    send(1, -5, -2, 1'b0);
    send(1, -1, -2, 1'b0);
    send(1, -1, -2, 1'b0);
    send(1, -1, -2, 1'b1);

    // Make ch2 the last winner so the rotation starts at ch0
    send(2, 100, 25, 1'b0);

    // Round robin with all channels requesting
    exp_g = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clock);
      ch_valid = '1;
      oready   = 1'b1;
      ch_data  = {16'($urandom), 16'($urandom), 16'($urandom)};
      #1;
      check("rr_grant", 64'(ch_ready), 64'(1 << exp_g));
      exp_g = (exp_g + 1) % NCHAN;
    end

    // Backpressure: pending result blocks all grants
    @(negedge clock);
    oready = 1'b0;
    #1;
    check("bp_ready", 64'(ch_ready), 64'd0);
    repeat (5) begin
      @(negedge clock);
      ch_data = {16'($urandom), 16'($urandom), 16'($urandom)};
      #1;
      check("bp_ready", 64'(ch_ready), 64'd0);
      check("bp_ovalid", 64'(ovalid), 64'd1);
    end
    @(negedge clock);
    oready = 1'b1;
    #1;
    check("bp_resume", 64'(ch_ready), 64'(1 << exp_g));
    @(negedge clock);
    ch_valid = '0;

    // Clear flushes channel contexts
    @(negedge clock);
    clear    = 1'b1;
    ch_valid = 3'b001;
    #1;
    check("clear_ready", 64'(ch_ready), 64'd0);
    @(negedge clock);
    clear    = 1'b0;
    ch_valid = '0;
    send(0, 40, 10, 1'b0);
    send(0, 40, 20, 1'b0);
    send(0, 40, 30, 1'b0);
    @(negedge clock);
    clear    = 1'b1;
    ch_valid = 3'b001;
    ch_data[0 +: WIDTH] = 16'd40;
    #1;
    check("clear_ready2", 64'(ch_ready), 64'd0);
    @(negedge clock);
    clear    = 1'b0;
    ch_valid = '0;
    send(0, 8, 2, 1'b0);

    // Asynchronous reset in the middle of a burst
    @(negedge clock);
    ch_valid = '1;
    oready   = 1'b1;
    repeat (3) begin
      ch_data = {16'($urandom), 16'($urandom), 16'($urandom)};
      @(negedge clock);
    end
    #3;
    reset_n = 1'b0;
    #1;
    check("async_ovalid", 64'(ovalid),   64'd0);
    check("async_odata",  64'(odata),    64'd0);
    check("async_ochan",  64'(ochan),    64'd0);
    check("async_ofull",  64'(ofull),    64'd0);
    check("async_ready",  64'(ch_ready), 64'd0);
    exp_q.delete();
    model_flush();
    @(negedge clock);
    reset_n = 1'b1;

    // Randomized traffic with random backpressure and occasional clears
    repeat (400) begin
      @(negedge clock);
      ch_valid = NCHAN'($urandom);
      ch_data  = {16'($urandom), 16'($urandom), 16'($urandom)};
      oready   = ($urandom_range(0, 3) != 0);
      clear    = ($urandom_range(0, 31) == 0);
    end

    @(negedge clock);
    ch_valid = '0;
    clear    = 1'b0;
    oready   = 1'b1;
    repeat (3) @(negedge clock);
    check("drain_empty", 64'(exp_q.size()), 64'd0);
    check("drain_ovalid", 64'(ovalid), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
